// File: rtl/axis_len_pkg.sv
// Shared header format and FSM state encoding for the length-framed AXI-Stream blocks.
// Also used by the length-prepending packetiser.
package axis_len_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ID_MSB  = 63;
    localparam int unsigned ID_LSB  = 56;
    localparam int unsigned LEN_MSB = 15;
    localparam int unsigned LEN_LSB = 0;
    localparam int unsigned ID_W    = ID_MSB - ID_LSB + 1;
    localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;
    localparam int unsigned RSVD_W  = ID_LSB - LEN_MSB - 1;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [RSVD_W-1:0] rsvd;
        logic [LEN_W-1:0]  len;
    } header_t;

    // One stream beat as carried through the output skid buffer.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    function automatic header_t make_header(input logic [ID_W-1:0] id,
                                            input logic [LEN_W-1:0] len);
        header_t h;
        h      = '0;
        h.id   = id;
        h.len  = len;
        return h;
    endfunction

    function automatic logic len_in_range(input logic [LEN_W-1:0] len,
                                          input int unsigned max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: fully registered output, ready derived from a flop.
module axis_skid_buffer
    import axis_len_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  beat_t in_beat,
    input  logic  in_valid,
    output logic  in_ready,
    output beat_t out_beat,
    output logic  out_valid,
    input  logic  out_ready
);

    beat_t skid_beat;
    logic  skid_valid;

    assign in_ready = ~skid_valid;

    // Main register refills from the skid entry first so ordering is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_beat   <= '0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_beat   <= skid_beat;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_beat <= in_beat;
                end
            end
        end else if (in_valid && !skid_valid) begin
            skid_beat  <= in_beat;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_len_stripper.sv
// Strips a length header from a 64-bit AXI-Stream and enforces the declared payload length.
// Error/packet counters are built only when AXIS_LEN_STRIP_STATS_EN is defined.
module axis_len_stripper
    import axis_len_pkg::*;
#(
    parameter logic [ID_W-1:0] ID          = 8'hF0,
    parameter int unsigned     MAX_PKT_LEN = 64,
    parameter int unsigned     CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 clear_counters,
    input  logic [DATA_W-1:0]    in_tdata,
    input  logic                 in_tvalid,
    input  logic                 in_tlast,
    output logic                 in_tready,
    output logic [DATA_W-1:0]    out_tdata,
    output logic                 out_tvalid,
    output logic                 out_tlast,
    input  logic                 out_tready,
    output logic [31:0]          pkt_count,
    output logic [CNT_WIDTH-1:0] err_id,
    output logic [CNT_WIDTH-1:0] err_len,
    output logic [CNT_WIDTH-1:0] err_short,
    output logic [CNT_WIDTH-1:0] err_long
);

    state_e           state;
    state_e           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    header_t          hdr;
    logic             ready_c;
    logic             buf_valid;
    logic             buf_ready;
    logic             buf_last;
    beat_t            buf_in;
    beat_t            buf_out;
    logic             inc_pkt;
    logic             inc_id;
    logic             inc_len;
    logic             inc_short;
    logic             inc_long;
    logic             unused_rsvd;

    assign hdr         = header_t'(in_tdata);
    assign unused_rsvd = ^hdr.rsvd;
    assign in_tready   = ready_c & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_c   = 1'b0;
        buf_valid = 1'b0;
        buf_last  = 1'b0;
        inc_pkt   = 1'b0;
        inc_id    = 1'b0;
        inc_len   = 1'b0;
        inc_short = 1'b0;
        inc_long  = 1'b0;
        case (state)
            HDR: begin
                ready_c = ena;
                if (in_tvalid && ena) begin
                    if (hdr.id != ID) begin
                        inc_id    = 1'b1;
                        state_nxt = in_tlast ? HDR : DROP;
                    end else if (!len_in_range(hdr.len, MAX_PKT_LEN)) begin
                        inc_len   = 1'b1;
                        state_nxt = in_tlast ? HDR : DROP;
                    end else if (in_tlast) begin
                        inc_short = 1'b1;
                    end else begin
                        cnt_nxt   = hdr.len;
                        state_nxt = PAY;
                    end
                end
            end
            PAY: begin
                ready_c   = buf_ready;
                buf_valid = in_tvalid;
                if (in_tvalid && buf_ready) begin
                    cnt_nxt = cnt - LEN_W'(1);
                    if (in_tlast) begin
                        buf_last  = 1'b1;
                        state_nxt = HDR;
                        if (cnt == LEN_W'(1)) begin
                            inc_pkt = 1'b1;
                        end else begin
                            inc_short = 1'b1;
                        end
                    end else if (cnt == LEN_W'(1)) begin
                        // Declared length reached but the frame goes on: close it, drop the rest.
                        buf_last  = 1'b1;
                        inc_long  = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                ready_c = 1'b1;
                if (in_tvalid && in_tlast) begin
                    state_nxt = HDR;
                end
            end
            default: begin
                state_nxt = HDR;
            end
        endcase
    end

    assign buf_in = '{last: buf_last, data: in_tdata};

    axis_skid_buffer u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_beat   (buf_in),
        .in_valid  (buf_valid),
        .in_ready  (buf_ready),
        .out_beat  (buf_out),
        .out_valid (out_tvalid),
        .out_ready (out_tready)
    );

    assign out_tdata = buf_out.data;
    assign out_tlast = buf_out.last;

`ifdef AXIS_LEN_STRIP_STATS_EN
    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clear_counters) begin
            pkt_count <= '0;
            err_id    <= '0;
            err_len   <= '0;
            err_short <= '0;
            err_long  <= '0;
        end else begin
            if (inc_pkt && pkt_count != '1) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (inc_id && err_id != '1) begin
                err_id <= err_id + CNT_WIDTH'(1);
            end
            if (inc_len && err_len != '1) begin
                err_len <= err_len + CNT_WIDTH'(1);
            end
            if (inc_short && err_short != '1) begin
                err_short <= err_short + CNT_WIDTH'(1);
            end
            if (inc_long && err_long != '1) begin
                err_long <= err_long + CNT_WIDTH'(1);
            end
        end
    end
`else
    logic unused_stats;

    assign unused_stats = ^{clear_counters, inc_pkt, inc_id, inc_len, inc_short, inc_long};
    assign pkt_count    = '0;
    assign err_id       = '0;
    assign err_len      = '0;
    assign err_short    = '0;
    assign err_long     = '0;
`endif

endmodule

// File: tb/tb_axis_len_stripper.sv
// Directed bench for axis_len_stripper with an output scoreboard and a random-backpressure phase.
module tb_axis_len_stripper;
    import axis_len_pkg::*;

    localparam int unsigned CW = 4;
`ifdef AXIS_LEN_STRIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          ena;
    logic          clear_counters;
    logic [63:0]   in_tdata;
    logic          in_tvalid;
    logic          in_tlast;
    logic          in_tready;
    logic [63:0]   out_tdata;
    logic          out_tvalid;
    logic          out_tlast;
    logic          out_tready;
    logic [31:0]   pkt_count;
    logic [CW-1:0] err_id;
    logic [CW-1:0] err_len;
    logic [CW-1:0] err_short;
    logic [CW-1:0] err_long;

    axis_len_stripper #(.ID(8'hF0), .MAX_PKT_LEN(64), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .clear_counters(clear_counters),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
        .pkt_count(pkt_count), .err_id(err_id), .err_len(err_len),
        .err_short(err_short), .err_long(err_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [64:0] exp_q[$];
    int          m_pkt, m_id, m_len, m_short, m_long;
    int unsigned seq;
    bit          bp_en;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] g(input int n);
        return STATS ? 64'(n) : 64'd0;
    endfunction

    function automatic int sat(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic check_cnt(input string tag, input int p, input int i, input int l,
                             input int s, input int lg);
        check({tag, "_pkt"},   64'(pkt_count), g(p));
        check({tag, "_id"},    64'(err_id),    g(i));
        check({tag, "_len"},   64'(err_len),   g(l));
        check({tag, "_short"}, 64'(err_short), g(s));
        check({tag, "_long"},  64'(err_long),  g(lg));
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        int   n;
        logic r;
        in_tdata  = d;
        in_tlast  = l;
        in_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            r = in_tready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 500) begin
                check("send_timeout", 64'(r), 64'd1);
                break;
            end
        end
    endtask

    task automatic idle();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    // Builds a frame, records the expected output and counter effects, then drives it.
    task automatic send_pkt(input logic [7:0] id, input int len, input int nw, input bit ena_drop);
        logic [63:0] w[$];
        int          k;
        for (int i = 0; i < nw; i++) begin
            w.push_back({32'(seq), 32'(i)});
        end
        seq++;
        if (id != 8'hF0) begin
            m_id++;
        end else if (len == 0 || len > 64) begin
            m_len++;
        end else if (nw == 0) begin
            m_short++;
        end else begin
            k = (nw < len) ? nw : len;
            for (int i = 0; i < k; i++) begin
                exp_q.push_back({1'(i == k - 1), w[i]});
            end
            if (nw == len)     m_pkt++;
            else if (nw < len) m_short++;
            else               m_long++;
        end
        send({id, 40'h5A_A5C3_3C96, 16'(len)}, nw == 0);
        if (ena_drop) ena = 1'b0;
        for (int i = 0; i < nw; i++) begin
            send(w[i], i == nw - 1);
        end
        ena = 1'b1;
        idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: scoreboard compare plus hold-stability under backpressure.
    logic        hold_v = 1'b0;
    logic [63:0] hold_d;
    logic        hold_l;
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 64'(out_tvalid), 64'd1);
                check("stall_data",  out_tdata,       hold_d);
                check("stall_last",  64'(out_tlast),  64'(hold_l));
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_tdata,      e[63:0]);
                    check("out_last", 64'(out_tlast), 64'(e[64]));
                end
            end
            hold_v = out_tvalid && !out_tready;
            hold_d = out_tdata;
            hold_l = out_tlast;
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1 out_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rid;
        int         rlen;
        int         rsel;
        rst = 1'b1; ena = 1'b1; clear_counters = 1'b0;
        in_tvalid = 1'b1; in_tdata = {8'hF0, 40'h0, 16'd1}; in_tlast = 1'b0;
        out_tready = 1'b1; bp_en = 1'b0; seq = 0;
        m_pkt = 0; m_id = 0; m_len = 0; m_short = 0; m_long = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_tready",  64'(in_tready),  64'd0);
        check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        check("rst_out_tlast",  64'(out_tlast),  64'd0);
        check("rst_out_tdata",  out_tdata,       64'd0);
        check_cnt("rst", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // Good 3-word packet with latency checks
        exp_q.push_back({1'b0, 64'h1111});
        exp_q.push_back({1'b0, 64'h2222});
        exp_q.push_back({1'b1, 64'h3333});
        send({8'hF0, 40'h0, 16'd3}, 1'b0);
        check("t1_hdr_no_out", 64'(out_tvalid), 64'd0);
        send(64'h1111, 1'b0);
        check("t1_lat_valid", 64'(out_tvalid), 64'd1);
        check("t1_lat_data",  out_tdata,       64'h1111);
        check("t1_lat_last",  64'(out_tlast),  64'd0);
        send(64'h2222, 1'b0);
        send(64'h3333, 1'b1);
        check("t1_last_data", out_tdata,      64'h3333);
        check("t1_last",      64'(out_tlast), 64'd1);
        idle();
        drain();
        check_cnt("t1", 1, 0, 0, 0, 0);

        // Bad ID dropped, next good packet passes
        send_pkt(8'hA5, 4, 4, 1'b0);
        check_cnt("t2_badid", 1, 1, 0, 0, 0);
        send_pkt(8'hF0, 2, 2, 1'b0);
        drain();
        check_cnt("t2_good", 2, 1, 0, 0, 0);

        // Short, long, over-length, max-length, header-only
        send_pkt(8'hF0, 5, 2, 1'b0);
        drain();
        check_cnt("t3_short", 2, 1, 0, 1, 0);
        send_pkt(8'hF0, 2, 4, 1'b0);
        drain();
        check_cnt("t4_long", 2, 1, 0, 1, 1);
        send_pkt(8'hF0, 65, 3, 1'b0);
        drain();
        check_cnt("t5_len65", 2, 1, 1, 1, 1);
        send_pkt(8'hF0, 64, 64, 1'b0);
        drain();
        check_cnt("t5_len64", 3, 1, 1, 1, 1);
        send_pkt(8'hF0, 3, 0, 1'b0);
        drain();
        check_cnt("t6_hdronly", 3, 1, 1, 2, 1);

        // ena gates only header acceptance
        ena = 1'b0;
        in_tdata = {8'hF0, 40'h0, 16'd2}; in_tlast = 1'b0; in_tvalid = 1'b1;
        @(negedge clk);
        check("t7_ena_gate", 64'(in_tready), 64'd0);
        @(posedge clk); #1;
        idle();
        ena = 1'b1;
        send_pkt(8'hF0, 3, 3, 1'b1);
        drain();
        check_cnt("t7_ena_mid", 4, 1, 1, 2, 1);

        // Directed backpressure: skid buffer fills, input stalls
        out_tready = 1'b0;
        exp_q.push_back({1'b0, 64'hA0});
        exp_q.push_back({1'b0, 64'hB0});
        exp_q.push_back({1'b1, 64'hC0});
        send({8'hF0, 40'h0, 16'd3}, 1'b0);
        send(64'hA0, 1'b0);
        send(64'hB0, 1'b0);
        @(negedge clk);
        check("t8_full_ready", 64'(in_tready),  64'd0);
        check("t8_held_valid", 64'(out_tvalid), 64'd1);
        check("t8_held_data",  out_tdata,       64'hA0);
        @(posedge clk); #1;
        out_tready = 1'b1;
        send(64'hC0, 1'b1);
        idle();
        drain();
        check_cnt("t8_bp", 5, 1, 1, 2, 1);

        // Reset mid-packet abandons buffered words
        out_tready = 1'b0;
        send({8'hF0, 40'h0, 16'd4}, 1'b0);
        send(64'hDEAD, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        check("t9_rst_valid", 64'(out_tvalid), 64'd0);
        check("t9_rst_last",  64'(out_tlast),  64'd0);
        check_cnt("t9_rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        out_tready = 1'b1;
        send_pkt(8'hF0, 1, 1, 1'b0);
        drain();
        check_cnt("t9_after", 1, 0, 0, 0, 0);

        // Saturation and clear priority (4-bit counters)
        repeat (16) send_pkt(8'hA5, 1, 0, 1'b0);
        check_cnt("t10_sat", 1, 15, 0, 0, 0);
        send_pkt(8'hA5, 1, 0, 1'b0);
        check_cnt("t10_sat_hold", 1, 15, 0, 0, 0);
        clear_counters = 1'b1;
        send_pkt(8'hA5, 1, 0, 1'b0);
        clear_counters = 1'b0;
        check_cnt("t10_clear", 0, 0, 0, 0, 0);

        // Random frames with 50% output backpressure
        m_pkt = 0; m_id = 0; m_len = 0; m_short = 0; m_long = 0;
        bp_en = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            rid  = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'hF0;
            rsel = int'($urandom_range(0, 19));
            rlen = (rsel == 0) ? 0 : (rsel == 1) ? 65 : int'($urandom_range(1, 6));
            send_pkt(rid, rlen, int'($urandom_range(0, 7)), 1'b0);
        end
        bp_en = 1'b0;
        @(posedge clk); #2;
        out_tready = 1'b1;
        drain();
        check_cnt("t11_rand", m_pkt, sat(m_id), sat(m_len), sat(m_short), sat(m_long));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
